// File: rtl/dbg_led_scope.sv
// dbg_led_scope -- board-level debug viewer.
// Shows one LED_W-bit slice (or the flag bits) of one of NCH probe channels
// on the board LEDs. Slices can be picked by switches or auto-scanned on a
// dwell timer, and a push button toggles a frozen snapshot of the channel.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   ch_data     probe data, channel k at [k*DATA_W +: DATA_W] (clk domain)
//   ch_flags    probe flags, channel k at [k*FLAG_W +: FLAG_W] (clk domain)
//   ch_sel      channel select switches (asynchronous)
//   sl_sel      slice select switches (asynchronous)
//   show_flags  switch, 1 = show flags instead of data (asynchronous)
//   auto        switch, 1 = auto-scan slices (asynchronous)
//   freeze_btn  push button, each press toggles freeze (asynchronous)
//   led         registered display output
//   cur_sl      slice index currently on the LEDs
//   frozen      1 while the snapshot is displayed
module dbg_led_scope #(
    parameter int DATA_W      = 32,
    parameter int LED_W       = 8,
    parameter int NCH         = 4,
    parameter int FLAG_W      = 2,
    parameter int DWELL       = 25000000,
    parameter int SYNC_STAGES = 2,
    localparam int NSL        = DATA_W / LED_W,
    localparam int CH_BITS    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SL_BITS    = (NSL > 1) ? $clog2(NSL) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*DATA_W-1:0]    ch_data,
    input  logic [NCH*FLAG_W-1:0]    ch_flags,
    input  logic [CH_BITS-1:0]       ch_sel,
    input  logic [SL_BITS-1:0]       sl_sel,
    input  logic                     show_flags,
    input  logic                     auto,
    input  logic                     freeze_btn,
    output logic [LED_W-1:0]         led,
    output logic [SL_BITS-1:0]       cur_sl,
    output logic                     frozen
);

    localparam int SW    = CH_BITS + SL_BITS + 3;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SW-1:0]      sync_q [SYNC_STAGES];
    logic [CH_BITS-1:0] ch_sel_s;
    logic [SL_BITS-1:0] sl_sel_s;
    logic               flags_s;
    logic               auto_s;
    logic               btn_s;
    logic               btn_prev;
    logic               btn_rise;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SL_BITS-1:0] cur_sl_nxt;

    logic [DATA_W-1:0]  live_data;
    logic [FLAG_W-1:0]  live_flags;
    logic [DATA_W-1:0]  snap_data;
    logic [FLAG_W-1:0]  snap_flags;
    logic [DATA_W-1:0]  src_data;
    logic [FLAG_W-1:0]  src_flags;
    logic [LED_W-1:0]   led_nxt;

    // All switch/button inputs share one synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {ch_sel, sl_sel, show_flags, auto, freeze_btn};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {ch_sel_s, sl_sel_s, flags_s, auto_s, btn_s} = sync_q[SYNC_STAGES-1];
    assign btn_rise = btn_s & ~btn_prev;

    // Live channel mux; an out-of-range select (non-power-of-2 NCH) reads 0.
    always_comb begin
        live_data  = '0;
        live_flags = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_sel_s == CH_BITS'(k)) begin
                live_data  = ch_data[k*DATA_W +: DATA_W];
                live_flags = ch_flags[k*FLAG_W +: FLAG_W];
            end
        end
    end

    assign src_data  = frozen ? snap_data  : live_data;
    assign src_flags = frozen ? snap_flags : live_flags;

    // Slice index and dwell timer. Entering auto mode leaves the counter at 0
    // and the index where it was, so scanning starts from the shown slice.
    always_comb begin
        cnt_nxt    = cnt;
        cur_sl_nxt = cur_sl;
        if (!auto_s) begin
            cnt_nxt    = '0;
            cur_sl_nxt = sl_sel_s;
        end else if (cnt == CNT_W'(DWELL - 1)) begin
            cnt_nxt    = '0;
            cur_sl_nxt = (cur_sl >= SL_BITS'(NSL - 1)) ? '0 : cur_sl + SL_BITS'(1);
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // The LED slice is chosen with the index being registered into cur_sl on
    // the same edge, so cur_sl always labels what is on the LEDs and a slice
    // switch reaches the LEDs SYNC_STAGES+1 cycles after it moves.
    always_comb begin
        led_nxt = '0;
        if (flags_s) begin
            led_nxt = LED_W'(src_flags);
        end else begin
            for (int k = 0; k < NSL; k++) begin
                if (cur_sl_nxt == SL_BITS'(k)) led_nxt = src_data[k*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev   <= 1'b0;
            cnt        <= '0;
            cur_sl     <= '0;
            frozen     <= 1'b0;
            snap_data  <= '0;
            snap_flags <= '0;
            led        <= '0;
        end else begin
            btn_prev <= btn_s;
            cnt      <= cnt_nxt;
            cur_sl   <= cur_sl_nxt;
            led      <= led_nxt;
            if (btn_rise) begin
                frozen <= ~frozen;
                if (!frozen) begin
                    snap_data  <= live_data;
                    snap_flags <= live_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbg_led_scope.sv
module tb_dbg_led_scope;

    localparam int DATA_W = 32;
    localparam int LED_W  = 8;
    localparam int NCH    = 4;
    localparam int FLAG_W = 2;
    localparam int DWELL  = 4;
    localparam int SS     = 2;
    localparam int NSL    = DATA_W / LED_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NCH*DATA_W-1:0] ch_data;
    logic [NCH*FLAG_W-1:0] ch_flags;
    logic [1:0]            ch_sel = '0;
    logic [1:0]            sl_sel = '0;
    logic                  show_flags = 1'b0;
    logic                  auto = 1'b0;
    logic                  freeze_btn = 1'b0;
    logic [LED_W-1:0]      led;
    logic [1:0]            cur_sl;
    logic                  frozen;

    logic [DATA_W-1:0] chd [NCH] = '{default: '0};
    logic [FLAG_W-1:0] chf [NCH] = '{default: '0};

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ch_data[k*DATA_W +: DATA_W]  = chd[k];
            ch_flags[k*FLAG_W +: FLAG_W] = chf[k];
        end
    end

    dbg_led_scope #(
        .DATA_W(DATA_W), .LED_W(LED_W), .NCH(NCH), .FLAG_W(FLAG_W),
        .DWELL(DWELL), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_flags(ch_flags),
        .ch_sel(ch_sel), .sl_sel(sl_sel), .show_flags(show_flags),
        .auto(auto), .freeze_btn(freeze_btn),
        .led(led), .cur_sl(cur_sl), .frozen(frozen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Switch values reach the logic SS edges after they are sampled, so the
    // model keeps a FIFO of raw switch samples SS entries deep.
    typedef struct {int ch; int sl; int sf; int au; int bt;} sw_t;
    sw_t swq [$];
    int m_led = 0, m_sl = 0, m_cnt = 0, m_frz = 0, m_prev = 0;
    logic [DATA_W-1:0] m_snap_d = '0;
    logic [FLAG_W-1:0] m_snap_f = '0;

    function automatic void m_reset();
        m_led = 0; m_sl = 0; m_cnt = 0; m_frz = 0; m_prev = 0;
        m_snap_d = '0; m_snap_f = '0;
        swq.delete();
        for (int i = 0; i < SS; i++) swq.push_back('{0, 0, 0, 0, 0});
    endfunction

    initial m_reset();
    always @(negedge rst) m_reset();

    always @(posedge clk) begin
        sw_t u;
        logic [DATA_W-1:0] live_d, src_d;
        logic [FLAG_W-1:0] live_f, src_f;
        if (!rst) begin
            m_reset();
        end else begin
            swq.push_back('{int'(ch_sel), int'(sl_sel), int'(show_flags), int'(auto), int'(freeze_btn)});
            u = swq.pop_front();
            live_d = (u.ch < NCH) ? chd[u.ch] : '0;
            live_f = (u.ch < NCH) ? chf[u.ch] : '0;
            src_d  = (m_frz != 0) ? m_snap_d : live_d;
            src_f  = (m_frz != 0) ? m_snap_f : live_f;
            if (u.au == 0) begin
                m_sl  = u.sl;
                m_cnt = 0;
            end else if (m_cnt == DWELL - 1) begin
                m_cnt = 0;
                m_sl  = (m_sl >= NSL - 1) ? 0 : m_sl + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (u.bt != 0 && m_prev == 0) begin
                if (m_frz == 0) begin
                    m_snap_d = live_d;
                    m_snap_f = live_f;
                end
                m_frz = (m_frz == 0) ? 1 : 0;
            end
            m_prev = u.bt;
            if (u.sf != 0) m_led = int'(src_f);
            else if (m_sl < NSL) m_led = int'((src_d >> (LED_W * m_sl)) & 32'hFF);
            else m_led = 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_led", int'(led), m_led);
        chk("cyc_cur_sl", int'(cur_sl), m_sl);
        chk("cyc_frozen", int'(frozen), m_frz);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        freeze_btn = 1'b1;
        tick(2);
        freeze_btn = 1'b0;
        tick(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_sl;
        bit found;

        tick(2);
        rst = 1'b1;
        tick(1);
        chk("reset_led", int'(led), 0);
        chk("reset_cur_sl", int'(cur_sl), 0);
        chk("reset_frozen", int'(frozen), 0);

        // manual selection latency
        chd[2] = 32'hDEADBEEF; ch_sel = 2'd2; sl_sel = 2'd3;
        tick(2);
        chk("manual_before", int'(led), 8'h00);
        tick(1);
        chk("manual_sl3", int'(led), 8'hDE);
        sl_sel = 2'd0;
        tick(2);
        chk("manual_sl0_before", int'(led), 8'hDE);
        tick(1);
        chk("manual_sl0", int'(led), 8'hEF);

        // auto scan
        chd[0] = 32'h12345678; ch_sel = 2'd0; sl_sel = 2'd0;
        tick(4);
        chk("auto_start_led", int'(led), 8'h78);
        auto = 1'b1;
        tick(5);
        chk("auto_hold_sl", int'(cur_sl), 0);
        tick(1);
        chk("auto_sl1", int'(cur_sl), 1);
        chk("auto_led1", int'(led), 8'h56);
        tick(4);
        chk("auto_sl2", int'(cur_sl), 2);
        chk("auto_led2", int'(led), 8'h34);
        tick(4);
        chk("auto_sl3", int'(cur_sl), 3);
        chk("auto_led3", int'(led), 8'h12);
        tick(4);
        chk("auto_wrap_sl", int'(cur_sl), 0);
        chk("auto_wrap_led", int'(led), 8'h78);
        auto = 1'b0;

        // freeze
        chd[1] = 32'hCAFEF00D; ch_sel = 2'd1; sl_sel = 2'd0;
        tick(4);
        chk("frz_live", int'(led), 8'h0D);
        freeze_btn = 1'b1;
        tick(2);
        freeze_btn = 1'b0;
        tick(3);
        chk("frz_on", int'(frozen), 1);
        chd[1] = '0; chd[0] = '0; ch_sel = 2'd0;
        tick(4);
        chk("frz_hold_sl0", int'(led), 8'h0D);
        sl_sel = 2'd2;
        tick(4);
        chk("frz_hold_sl2", int'(led), 8'hFE);
        freeze_btn = 1'b1;
        tick(4);
        chk("frz_held_off", int'(frozen), 0);
        tick(16);
        chk("frz_held_once", int'(frozen), 0);
        freeze_btn = 1'b0;
        tick(4);
        chk("frz_off_led", int'(led), 8'h00);
        press();
        chk("frz_press2", int'(frozen), 1);
        press();
        chk("frz_press3", int'(frozen), 0);
        chk("frz_press3_led", int'(led), 8'h00);

        // flags view
        chf[3] = 2'b10; ch_sel = 2'd3; show_flags = 1'b1;
        tick(4);
        chk("flags_led", int'(led), 8'h02);
        auto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(4);
            chk("flags_auto_led", int'(led), 8'h02);
        end

        // freeze edge coinciding with a dwell wrap
        show_flags = 1'b0;
        chd[3] = 32'hA5C35A3C;
        tick(4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (m_cnt == 1) found = 1'b1;
        end
        chk("sim_align_found", int'(found), 1);
        exp_sl = (m_sl + 1) % NSL;
        freeze_btn = 1'b1;
        tick(2);
        chk("sim_pre_frozen", int'(frozen), 0);
        tick(1);
        chk("sim_frozen", int'(frozen), 1);
        chk("sim_cur_sl", int'(cur_sl), exp_sl);
        freeze_btn = 1'b0;
        chd[3] = '0;
        auto = 1'b0; sl_sel = 2'd1;
        tick(3);
        chk("sim_snap_sl1", int'(led), 8'h5A);
        sl_sel = 2'd3;
        tick(3);
        chk("sim_snap_sl3", int'(led), 8'hA5);

        // asynchronous reset while scanning and frozen
        auto = 1'b1;
        tick(10);
        #2 rst = 1'b0;
        #1;
        chk("arst_led", int'(led), 0);
        chk("arst_cur_sl", int'(cur_sl), 0);
        chk("arst_frozen", int'(frozen), 0);
        auto = 1'b0; sl_sel = 2'd1; ch_sel = 2'd2;
        tick(1);
        rst = 1'b1;
        tick(2);
        chk("arst_resume_before", int'(led), 0);
        tick(1);
        chk("arst_resume", int'(led), 8'hBE);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) chd[$urandom_range(NCH-1)] = $urandom;
            if ($urandom_range(7) == 0) chf[$urandom_range(NCH-1)] = 2'($urandom);
            if ($urandom_range(15) == 0) ch_sel = 2'($urandom);
            if ($urandom_range(7) == 0) sl_sel = 2'($urandom);
            if ($urandom_range(31) == 0) show_flags = ~show_flags;
            if ($urandom_range(31) == 0) auto = ~auto;
            if ($urandom_range(5) == 0) freeze_btn = ~freeze_btn;
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b0;
                tick($urandom_range(3, 1));
                rst = 1'b1;
            end
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
